alu_seq: RTL
============

# alu_seq

Parametrised multi-cycle successor to the single-cycle CPU ALU. It keeps the eight logic and arithmetic operations with their existing encodings, and adds shifts plus iterative multiply, divide and remainder. Operands and results move through valid/ready handshakes, so a multi-cycle execute stage can stall on it. Operand B comes from ReadData2 or the sign-extended immediate, selected by ALUSrcB.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from B.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- ReadData1  in  WIDTH  operand A.
- ReadData2  in  WIDTH  register operand B.
- inExt  in  WIDTH  extended immediate.
- ALUSrcB  in  1  B = ALUSrcB ? inExt : ReadData2.
- ALUOp  in  4  operation code.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  registered; high when result == 0.
- div0  out  1  registered; high when the completed DIVU/REMU had B == 0.

## Operation
- Handshake: input fires when in_valid && in_ready. Output fires when out_valid && out_ready.
- On input fire, A, B (after the ALUSrcB mux) and ALUOp are captured. Later input changes have no effect.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on fire, ops 0–10 and 14–15 go to DONE; ops 11–13 go to CALC.
  - CALC: runs WIDTH iterations, one per cycle, then goes to DONE.
  - DONE: out_valid = 1; on output fire, return to IDLE.
- ALUOp encoding, arithmetic modulo 2^WIDTH:
  - 0: A+B
  - 1: A−B
  - 2: B−A
  - 3: A|B
  - 4: A&B
  - 5: ~A&B
  - 6: A^B
  - 7: ~(A^B)
  - 8: A << B[SHW-1:0]
  - 9: A >> B[SHW-1:0], logical
  - 10: arithmetic right shift of A by B[SHW-1:0]
  - 11: MUL, low WIDTH bits of A*B (shift-add)
  - 12: DIVU quotient, unsigned restoring division
  - 13: REMU remainder, unsigned restoring division
  - 14, 15: reserved; result = 0, zero = 1.
- Division by zero: DIVU gives all-ones, REMU gives A, div0 = 1. Takes the full WIDTH iterations, no early exit.
- div0 = 0 for every other op and for every completion with B ≠ 0.
- result, zero and div0 are written only on the transition into DONE. They hold until the next transition into DONE, and stay valid after the output handshake.
- Backpressure: while DONE and out_ready = 0, all outputs hold. in_ready stays 0.

## Timing
- Reset values:
  - state IDLE; in_ready 1; out_valid 0
  - result 0; zero 0; div0 0
  - iteration counter 0; internal operand and accumulator registers 0.
- Single-cycle ops (0–10, 14, 15): input fire at edge N → out_valid high after edge N+1.
- Iterative ops (11–13): input fire at edge N → out_valid high after edge N+WIDTH+1.
- No back-to-back overlap: in_ready returns high the cycle after output fire. Minimum issue interval is 2 cycles.
- A new request presented with out_ready held high is accepted one cycle after the output fire.
- Reset asserted mid-CALC or in DONE: the operation is aborted immediately, with no output handshake. All outputs return to reset values asynchronously.
- Shift amount uses only the low SHW bits of B. Upper bits are ignored, so a shift by WIDTH acts as a shift by 0.

## Test plan
- Basic ops, WIDTH=32, ALUSrcB=0:
  - A=5, B=5, op1 → result 0, zero 1, 1 cycle after fire.
  - A=3, B=10, op2 → 7.
  - A=0xF0F0F0F0, B=0xFFFF0000, op7 → 0xF0F00F0F.
- Immediate and shifts: ALUSrcB=1, inExt=0xFFFFFFFC, ReadData2=7.
  - A=0x80000000, op10 → shift 28, result 0xFFFFFFF8.
  - op9 → 0x00000008.
  - ReadData2 is ignored throughout.
- Multiply: A=0xFFFFFFFF, B=3, op11 → 0xFFFFFFFD.
  - out_valid rises exactly 33 cycles after fire.
  - in_ready stays 0 throughout.
- Divide:
  - A=100, B=7: op12 → 14, op13 → 2.
  - A=100, B=0: op12 → 0xFFFFFFFF with div0 1; op13 → 100 with div0 1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after a MUL completes → result stable, in_ready 0, a second in_valid is ignored.
  - Assert rst at cycle 15 of a DIVU → out_valid 0, result 0, in_ready 1. The next op0 with 2+2 → 4.
- Reserved and width: op14 → result 0, zero 1.
  - Repeat the mul/div cases with WIDTH=8: 200/9 → 22 rem 2, latency 9 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/shift ops, iterative shift-add multiply and restoring divide/remainder.
// Results are registered on entry to DONE and held there until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] inExt,
  input  logic             ALUSrcB,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div0
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic             zero_q, div0_q;

  logic [WIDTH-1:0] b_in, alu_d, mul_acc_d, rem_d, quo_d, iter_d;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   trial;
  logic             fits, iter_op, last;

  always_comb begin
    b_in    = ALUSrcB ? inExt : ReadData2;
    sh      = b_in[SHW-1:0];
    iter_op = (ALUOp == 4'd11) || (ALUOp == 4'd12) || (ALUOp == 4'd13);
    case (ALUOp)
      4'd0:    alu_d = ReadData1 + b_in;
      4'd1:    alu_d = ReadData1 - b_in;
      4'd2:    alu_d = b_in - ReadData1;
      4'd3:    alu_d = ReadData1 | b_in;
      4'd4:    alu_d = ReadData1 & b_in;
      4'd5:    alu_d = ~ReadData1 & b_in;
      4'd6:    alu_d = ReadData1 ^ b_in;
      4'd7:    alu_d = ~(ReadData1 ^ b_in);
      4'd8:    alu_d = ReadData1 << sh;
      4'd9:    alu_d = ReadData1 >> sh;
      4'd10:   alu_d = $unsigned($signed(ReadData1) >>> sh);
      default: alu_d = '0;
    endcase

    // Multiply: a_q is the shifting multiplicand, b_q the shifting multiplier.
    mul_acc_d = b_q[0] ? acc_q + a_q : acc_q;

    // Divide: acc_q is the partial remainder, a_q shifts the dividend out and the quotient in.
    trial = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    fits  = ~trial[WIDTH];
    rem_d = fits ? trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
    quo_d = {a_q[WIDTH-2:0], fits};

    case (op_q)
      4'd11:   iter_d = mul_acc_d;
      4'd12:   iter_d = quo_d;
      default: iter_d = rem_d;
    endcase
    last = (cnt_q == SHW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= ALUOp;
          if (iter_op) begin
            state_q <= CALC;
            a_q     <= ReadData1;
            b_q     <= b_in;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q  <= DONE;
            result_q <= alu_d;
            zero_q   <= (alu_d == '0);
            div0_q   <= 1'b0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == 4'd11) begin
            acc_q <= mul_acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= rem_d;
            a_q   <= quo_d;
          end
          // The final iteration's combinational result goes straight into the output register.
          if (last) begin
            state_q  <= DONE;
            result_q <= iter_d;
            zero_q   <= (iter_d == '0);
            div0_q   <= (op_q != 4'd11) && (b_q == '0);
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule
